// File: rtl/P65816.sv
// P65816: types and helpers shared by the 65C816 core blocks.
//   ALUCtrl_r    - ALU control word (fstOp / secOp / fc)
//   rmw_state_e  - state encoding of the read-modify-write sequencer
//   SECOP_TSB_TRB, is_shift_op - operation-class decode used for flag enables
package P65816;

    typedef struct packed {
        logic [2:0] fstOp;
        logic [2:0] secOp;
        logic       fc;
    } ALUCtrl_r;

    typedef enum logic [2:0] {
        RMW_IDLE,
        RMW_RD_LO,
        RMW_RD_HI,
        RMW_MODIFY,
        RMW_WR_HI,
        RMW_WR_LO,
        RMW_DONE
    } rmw_state_e;

    localparam logic [2:0] SECOP_TSB_TRB = 3'b101;

    // Shift/rotate group (ASL/ROL/LSR/ROR) is the only one that writes C.
    function automatic logic is_shift_op(input ALUCtrl_r ctrl);
        return ~ctrl.fstOp[2];
    endfunction

endpackage

// File: rtl/rmw_seq.sv
// rmw_seq: read-modify-write sequencer for 65C816 memory-operand
// shift/rotate/inc/dec/TSB/TRB. Fetches an 8/16-bit operand over the byte
// bus, lets the external ALU compute, latches result and flags, writes back.
//
// Ports
//   CLK, RST_N, EN             clock, async active-low reset, clock enable
//   start, op_ctrl, op_w16,
//   op_addr, acc               operation request from the microcode sequencer
//   busy, done                 status; done is a one-cycle completion pulse
//   mem_*                      byte bus master (req held until ack)
//   alu_l/alu_r/alu_ctrl/
//   alu_w16, alu_res, alu_*o   connection to the parent's ALU
//   flag_*, flag_*_we          latched N/Z/C and their write strobes
//
// state      | meaning
// -----------+-------------------------------------------------
// RMW_IDLE   | waiting for start
// RMW_RD_LO  | reading low byte at addr
// RMW_RD_HI  | reading high byte at addr_hi (16-bit only)
// RMW_MODIFY | latching ALU result and flags
// RMW_WR_HI  | writing result[15:8] to addr_hi (16-bit only)
// RMW_WR_LO  | writing result[7:0] to addr
// RMW_DONE   | completion; done and flag strobes follow next cycle
module rmw_seq
    import P65816::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              start,
    input  ALUCtrl_r          op_ctrl,
    input  logic              op_w16,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [15:0]       acc,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       alu_l,
    output logic [15:0]       alu_r,
    output ALUCtrl_r          alu_ctrl,
    output logic              alu_w16,
    input  logic [15:0]       alu_res,
    input  logic              alu_co,
    input  logic              alu_zo,
    input  logic              alu_so,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n_we,
    output logic              flag_z_we,
    output logic              flag_c_we
);

    rmw_state_e        state_q, state_d;
    ALUCtrl_r          ctrl_q, ctrl_d;
    logic              w16_q, w16_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       operand_q, operand_d;
    logic [15:0]       result_q, result_d;
    logic              n_q, n_d, z_q, z_d, c_q, c_d;
    logic              done_q, done_d;
    logic              n_we_q, n_we_d, z_we_q, z_we_d, c_we_q, c_we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              ack_ok;
    logic [ADDR_W-1:0] addr_hi;

    // Returns {N, Z, C} write enables for the captured operation.
    function automatic logic [2:0] flag_en(input ALUCtrl_r ctrl);
        return {ctrl.secOp != SECOP_TSB_TRB, 1'b1, is_shift_op(ctrl)};
    endfunction

    // An ack only counts against a request we are actually driving.
    assign ack_ok  = mem_ack & mem_req_q;
    // High byte stays in the same bank: the offset wraps, the bank never carries.
    assign addr_hi = {addr_q[ADDR_W-1:16], addr_q[15:0] + 16'd1};

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        w16_d       = w16_q;
        addr_d      = addr_q;
        operand_d   = operand_q;
        result_d    = result_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        done_d      = 1'b0;
        n_we_d      = 1'b0;
        z_we_d      = 1'b0;
        c_we_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 8'h00;

        case (state_q)
            RMW_IDLE: begin
                if (start) begin
                    ctrl_d  = op_ctrl;
                    w16_d   = op_w16;
                    addr_d  = op_addr;
                    state_d = RMW_RD_LO;
                end
            end
            RMW_RD_LO: begin
                if (ack_ok) begin
                    operand_d = {8'h00, mem_rdata};
                    state_d   = w16_q ? RMW_RD_HI : RMW_MODIFY;
                end
            end
            RMW_RD_HI: begin
                if (ack_ok) begin
                    operand_d[15:8] = mem_rdata;
                    state_d         = RMW_MODIFY;
                end
            end
            RMW_MODIFY: begin
                result_d = alu_res;
                n_d      = alu_so;
                z_d      = alu_zo;
                c_d      = alu_co;
                state_d  = w16_q ? RMW_WR_HI : RMW_WR_LO;
            end
            RMW_WR_HI: begin
                if (ack_ok) state_d = RMW_WR_LO;
            end
            RMW_WR_LO: begin
                if (ack_ok) state_d = RMW_DONE;
            end
            RMW_DONE: begin
                state_d                  = RMW_IDLE;
                done_d                   = 1'b1;
                {n_we_d, z_we_d, c_we_d} = flag_en(ctrl_q);
            end
            default: state_d = RMW_IDLE;
        endcase

        // Bus outputs are registered from the state being entered, so a
        // request is on the bus in the first cycle of its access state.
        case (state_d)
            RMW_RD_LO: begin
                mem_req_d  = 1'b1;
                mem_addr_d = addr_d;
            end
            RMW_RD_HI: begin
                mem_req_d  = 1'b1;
                mem_addr_d = addr_hi;
            end
            RMW_WR_HI: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_hi;
                mem_wdata_d = result_d[15:8];
            end
            RMW_WR_LO: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_d;
                mem_wdata_d = result_d[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RMW_IDLE;
            ctrl_q      <= '0;
            w16_q       <= 1'b0;
            addr_q      <= '0;
            operand_q   <= 16'h0000;
            result_q    <= 16'h0000;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            done_q      <= 1'b0;
            n_we_q      <= 1'b0;
            z_we_q      <= 1'b0;
            c_we_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
        end else if (EN) begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            w16_q       <= w16_d;
            addr_q      <= addr_d;
            operand_q   <= operand_d;
            result_q    <= result_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            done_q      <= done_d;
            n_we_q      <= n_we_d;
            z_we_q      <= z_we_d;
            c_we_q      <= c_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != RMW_IDLE);
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign alu_l     = acc;
    assign alu_r     = operand_q;
    assign alu_ctrl  = ctrl_q;
    assign alu_w16   = w16_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_n_we = n_we_q;
    assign flag_z_we = z_we_q;
    assign flag_c_we = c_we_q;

endmodule

// File: tb/tb_rmw_seq.sv
// Bench for rmw_seq: acts as the parent (ALU + byte memory slave with wait
// states and random EN), predicts every bus transfer, the done cycle and the
// flags from the instruction semantics, and compares each cycle.
module tb_rmw_seq;
    import P65816::*;

    localparam int ADDR_W = 24;

    logic              CLK = 1'b0;
    logic              RST_N, EN, start, op_w16, mem_ack;
    ALUCtrl_r          op_ctrl, alu_ctrl;
    logic [ADDR_W-1:0] op_addr, mem_addr;
    logic [15:0]       acc, alu_l, alu_r, alu_res;
    logic              busy, done, mem_req, mem_we, alu_w16;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              alu_co, alu_zo, alu_so;
    logic              flag_n, flag_z, flag_c, flag_n_we, flag_z_we, flag_c_we;

    always #5 CLK = ~CLK;

    rmw_seq #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .start(start),
        .op_ctrl(op_ctrl), .op_w16(op_w16), .op_addr(op_addr), .acc(acc),
        .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_l(alu_l), .alu_r(alu_r), .alu_ctrl(alu_ctrl), .alu_w16(alu_w16),
        .alu_res(alu_res), .alu_co(alu_co), .alu_zo(alu_zo), .alu_so(alu_so),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n_we(flag_n_we), .flag_z_we(flag_z_we), .flag_c_we(flag_c_we)
    );

    // ---------------- behavioural ALU (instruction semantics) ----------------
    typedef struct packed {
        logic [15:0] res;
        logic        n;
        logic        z;
        logic        c;
    } alu_out_t;

    function automatic alu_out_t alu_f(input ALUCtrl_r ctrl, input logic w16,
                                       input logic [15:0] l, input logic [15:0] r);
        int unsigned mask, msb, lv, rv, t;
        alu_out_t    o;
        bit          tsb;
        mask = w16 ? 32'hFFFF : 32'h00FF;
        msb  = w16 ? 32'h8000 : 32'h0080;
        lv   = 32'(l) & mask;
        rv   = 32'(r) & mask;
        o    = '0;
        tsb  = 1'b0;
        t    = rv;
        if (!ctrl.fstOp[2]) begin
            case (ctrl.fstOp[1:0])
                2'd0:    begin t = rv * 2;                      o.c = (rv & msb) != 0; end
                2'd1:    begin t = rv * 2 + 32'(ctrl.fc);       o.c = (rv & msb) != 0; end
                2'd2:    begin t = rv / 2;                      o.c = (rv % 2) != 0;   end
                default: begin t = rv / 2 + (ctrl.fc ? msb : 0); o.c = (rv % 2) != 0;  end
            endcase
        end else if (ctrl.secOp == 3'b101) begin
            tsb = 1'b1;
            t   = ctrl.fc ? (rv & ~lv) : (rv | lv);
        end else if (ctrl.secOp == 3'b110) begin
            t = rv + 1;
        end else if (ctrl.secOp == 3'b111) begin
            t = rv + mask;
        end
        t     = t & mask;
        o.res = t[15:0];
        o.n   = (t & msb) != 0;
        o.z   = tsb ? ((rv & lv) == 0) : (t == 0);
        return o;
    endfunction

    alu_out_t alu_o;
    assign alu_o   = alu_f(alu_ctrl, alu_w16, alu_l, alu_r);
    assign alu_res = alu_o.res;
    assign alu_so  = alu_o.n;
    assign alu_zo  = alu_o.z;
    assign alu_co  = alu_o.c;

    // ---------------- memory, scoreboard, bookkeeping ----------------
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
        int          waits;
    } xfer_t;

    xfer_t       xq[$];
    logic        obs_we[$];
    logic [23:0] obs_addr[$];
    logic [7:0]  obs_data[$];

    int   checks = 0;
    int   failures = 0;
    int   done_edge;
    int   en_low_cnt;
    bit   aborted;
    logic got_n, got_z, got_c, got_nwe, got_zwe, got_cwe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_alu_r"}, alu_r, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tag, "_alu_w16"}, alu_w16, 0);
        chk({tag, "_flags"}, {flag_n, flag_z, flag_c}, 0);
        chk({tag, "_strobes"}, {flag_n_we, flag_z_we, flag_c_we}, 0);
    endtask

    // Runs one operation as the parent. wait_mode<0 = random waits per access.
    task automatic run_op(input ALUCtrl_r ctrl, input logic w16, input logic [23:0] addr,
                          input logic [15:0] a, input int wait_mode, input int en_low_pct,
                          input bit spam, input bit abort_wr_hi);
        logic [23:0] lo, hi, cap_addr;
        logic [15:0] opnd;
        logic [7:0]  cap_data;
        logic        cap_we, req_s;
        alu_out_t    e;
        xfer_t       x;
        int          target, en_edges, edges;
        bit          fin;

        lo   = addr;
        hi   = {addr[23:16], addr[15:0] + 16'd1};
        opnd = w16 ? {rd_mem(hi), rd_mem(lo)} : {8'h00, rd_mem(lo)};
        e    = alu_f(ctrl, w16, a, opnd);
        xq.delete();
        obs_we.delete();
        obs_addr.delete();
        obs_data.delete();
        x = '{we: 1'b0, addr: lo, data: 8'h00, waits: 0};
        xq.push_back(x);
        if (w16) begin
            x = '{we: 1'b0, addr: hi, data: 8'h00, waits: 0};
            xq.push_back(x);
            x = '{we: 1'b1, addr: hi, data: e.res[15:8], waits: 0};
            xq.push_back(x);
        end
        x = '{we: 1'b1, addr: lo, data: e.res[7:0], waits: 0};
        xq.push_back(x);
        target = xq.size() + 2;
        foreach (xq[i]) begin
            xq[i].waits = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
            target += xq[i].waits;
        end

        @(negedge CLK);
        op_ctrl = ctrl; op_w16 = w16; op_addr = addr; acc = a;
        start = 1'b1; EN = 1'b1; mem_ack = 1'b0;
        @(posedge CLK);
        en_edges = 0; edges = 0; done_edge = -1; en_low_cnt = 0; fin = 0;
        while (!fin) begin
            @(negedge CLK);
            chk("busy", busy, en_edges < target);
            chk("done", done, en_edges == target);
            chk("alu_l", alu_l, a);
            chk("alu_ctrl", alu_ctrl, ctrl);
            chk("alu_w16", alu_w16, w16);
            if (en_edges == target) begin
                if (done_edge < 0) done_edge = edges;
                chk("z_we", flag_z_we, 1);
                chk("n_we", flag_n_we, ctrl.secOp != 3'b101);
                chk("c_we", flag_c_we, !ctrl.fstOp[2]);
                chk("flag_z", flag_z, e.z);
                if (ctrl.secOp != 3'b101) chk("flag_n", flag_n, e.n);
                if (!ctrl.fstOp[2]) chk("flag_c", flag_c, e.c);
                {got_n, got_z, got_c} = {flag_n, flag_z, flag_c};
                {got_nwe, got_zwe, got_cwe} = {flag_n_we, flag_z_we, flag_c_we};
            end else begin
                chk("strobes_idle", {flag_n_we, flag_z_we, flag_c_we}, 0);
            end
            req_s = mem_req; cap_we = mem_we; cap_addr = mem_addr; cap_data = mem_wdata;
            if (mem_req) begin
                if (xq.size() == 0) chk("req_extra", 1, 0);
                else begin
                    chk("bus_we", mem_we, xq[0].we);
                    chk("bus_addr", mem_addr, xq[0].addr);
                    chk("bus_wdata", mem_wdata, xq[0].data);
                end
            end
            if (abort_wr_hi && mem_req && mem_we && xq.size() == 2) begin
                #2 RST_N = 1'b0;
                #1;
                chk("rst_req_async", mem_req, 0);
                chk("rst_busy_async", busy, 0);
                aborted = 1'b1;
                mem_ack = 1'b0;
                start   = 1'b0;
                return;
            end
            if (en_edges > target) fin = 1;
            if (edges > 600) begin
                chk("timeout", 1, 0);
                fin = 1;
            end
            if (!fin) begin
                EN    = ($urandom_range(0, 99) >= en_low_pct);
                start = spam && (en_edges < target) && ($urandom_range(0, 1) == 1);
                if (mem_req && xq.size() > 0 && xq[0].waits == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = xq[0].we ? 8'($urandom) : rd_mem(xq[0].addr);
                end else begin
                    mem_ack   = !mem_req && ($urandom_range(0, 3) == 0);
                    mem_rdata = 8'($urandom);
                end
                @(posedge CLK);
                edges++;
                if (!EN) begin
                    if (done_edge < 0) en_low_cnt++;
                end else begin
                    en_edges++;
                    if (req_s && xq.size() > 0) begin
                        if (mem_ack) begin
                            obs_we.push_back(cap_we);
                            obs_addr.push_back(cap_addr);
                            obs_data.push_back(cap_data);
                            if (cap_we) mem[cap_addr] = cap_data;
                            void'(xq.pop_front());
                        end else begin
                            xq[0].waits--;
                        end
                    end
                end
            end
        end
        chk("xfers_left", xq.size(), 0);
        start = 1'b0; mem_ack = 1'b0; EN = 1'b1;
    endtask

    ALUCtrl_r c;

    initial begin
        RST_N = 1'b0; EN = 1'b1; start = 1'b0; op_w16 = 1'b0; mem_ack = 1'b0;
        op_ctrl = '0; op_addr = '0; acc = '0; mem_rdata = '0; aborted = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_vals("por");
        RST_N = 1'b1;

        // 8-bit ASL
        mem[24'h7E0010] = 8'h81;
        c = '{fstOp: 3'b000, secOp: 3'b000, fc: 1'b0};
        run_op(c, 1'b0, 24'h7E0010, 16'h0000, 0, 0, 0, 0);
        chk("asl_latency", done_edge, 4);
        chk("asl_nxfer", obs_we.size(), 2);
        chk("asl_wr", {obs_we[1], obs_addr[1], obs_data[1]}, {1'b1, 24'h7E0010, 8'h02});
        chk("asl_nzc", {got_n, got_z, got_c}, 3'b001);
        chk("asl_cwe", got_cwe, 1);

        // 16-bit INC across bank-offset wrap
        mem[24'h00FFFF] = 8'hFF; mem[24'h000000] = 8'hFF;
        c = '{fstOp: 3'b100, secOp: 3'b110, fc: 1'b0};
        run_op(c, 1'b1, 24'h00FFFF, 16'h0000, 0, 0, 0, 0);
        chk("inc_latency", done_edge, 6);
        chk("inc_nxfer", obs_we.size(), 4);
        chk("inc_rd0", {obs_we[0], obs_addr[0]}, {1'b0, 24'h00FFFF});
        chk("inc_rd1", {obs_we[1], obs_addr[1]}, {1'b0, 24'h000000});
        chk("inc_wr_hi", {obs_we[2], obs_addr[2], obs_data[2]}, {1'b1, 24'h000000, 8'h00});
        chk("inc_wr_lo", {obs_we[3], obs_addr[3], obs_data[3]}, {1'b1, 24'h00FFFF, 8'h00});
        chk("inc_nz", {got_n, got_z}, 2'b01);
        chk("inc_cwe", got_cwe, 0);

        // 8-bit TSB
        mem[24'h123456] = 8'hF0;
        c = '{fstOp: 3'b100, secOp: 3'b101, fc: 1'b0};
        run_op(c, 1'b0, 24'h123456, 16'h000F, 0, 0, 0, 0);
        chk("tsb_wr", obs_data[1], 8'hFF);
        chk("tsb_z", got_z, 1);
        chk("tsb_strobes", {got_nwe, got_zwe, got_cwe}, 3'b010);

        // 16-bit ROR, 3 waits per access, EN toggling
        mem[24'h010200] = 8'h34; mem[24'h010201] = 8'h12;
        c = '{fstOp: 3'b011, secOp: 3'b000, fc: 1'b0};
        run_op(c, 1'b1, 24'h010200, 16'h5555, 3, 50, 0, 0);
        chk("ror_latency", done_edge, 6 + 12 + en_low_cnt);
        chk("ror_wr_hi", obs_data[2], 8'h09);
        chk("ror_wr_lo", obs_data[3], 8'h1A);

        // start pulsed while busy
        mem[24'h300000] = 8'h41;
        c = '{fstOp: 3'b100, secOp: 3'b110, fc: 1'b0};
        run_op(c, 1'b0, 24'h300000, 16'h0000, 1, 0, 1, 0);
        chk("spam_nxfer", obs_we.size(), 2);
        chk("spam_wr", obs_data[1], 8'h42);
        repeat (3) begin
            @(negedge CLK);
            chk("spam_idle", {busy, mem_req}, 2'b00);
        end

        // reset during WR_HI of 16-bit DEC
        mem[24'h020400] = 8'h00; mem[24'h020401] = 8'h10;
        c = '{fstOp: 3'b100, secOp: 3'b111, fc: 1'b0};
        run_op(c, 1'b1, 24'h020400, 16'h0000, 0, 0, 0, 1);
        chk("rst_reached", aborted, 1);
        RST_N = 1'b0; EN = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk_reset_vals("mid_rst");

        // randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [23:0] a24;
            logic        w;
            a24 = 24'($urandom);
            if ($urandom_range(0, 4) == 0) a24[15:0] = 16'hFFFF;
            w = 1'($urandom);
            mem[a24] = 8'($urandom);
            mem[{a24[23:16], a24[15:0] + 16'd1}] = 8'($urandom);
            c = 7'($urandom);
            run_op(c, w, a24, 16'($urandom), -1, 20, 1'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rmw_seq.md
# rmw_seq

Read-modify-write sequencer for the 65C816 core's memory-operand shift, rotate, inc/dec and test-and-set/reset instructions (ASL/ROL/LSR/ROR/INC/DEC/TSB/TRB on memory). It fetches the 8- or 16-bit operand over the byte-wide bus, runs it through the combinational ALU, latches result and flags, and writes the result back in 65C816 bus order. It sits between the core's microcode sequencer and the bus interface. It owns the ALU's R operand and control while `busy`.

## Interface
- `ADDR_W`, 24: bus address width; low 16 bits are the in-bank offset.
- `CLK`  in  1  system clock.
- `RST_N`  in  1  asynchronous active-low reset.
- `EN`  in  1  clock enable; state, registers and outputs hold when 0.
- `start`  in  1  one-cycle request; sampled only in IDLE with EN=1.
- `op_ctrl`  in  ALUCtrl_r  ALU control (fstOp/secOp/fc) for the operation.
- `op_w16`  in  1  16-bit operand when 1.
- `op_addr`  in  ADDR_W  operand address.
- `acc`  in  16  accumulator (ALU L operand, TSB/TRB mask).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse at completion.
- `mem_req`  out  1  bus request, held until acknowledged.
- `mem_we`  out  1  write when 1.
- `mem_addr`  out  ADDR_W  bus address.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.
- `mem_ack`  in  1  transfer complete this cycle; may be combinational from `mem_req`.
- `alu_l`, `alu_r`  out  16  ALU operands (`alu_l` = `acc`, `alu_r` = fetched operand).
- `alu_ctrl`  out  ALUCtrl_r  registered copy of `op_ctrl`.
- `alu_w16`  out  1  registered copy of `op_w16`.
- `alu_res`  in  16  ALU result.
- `alu_co`, `alu_zo`, `alu_so`  in  1  ALU carry, zero and sign flags.
- `flag_n`, `flag_z`, `flag_c`  out  1  latched flags, valid while `done`.
- `flag_n_we`, `flag_z_we`, `flag_c_we`  out  1  flag write strobes; each is 1 only while `done` is 1.

## Operation
- States: IDLE, RD_LO, RD_HI, MODIFY, WR_HI, WR_LO, DONE. Every transition requires EN=1.
- IDLE:
  - On `start`, capture ctrl, w16 and addr, then go to RD_LO.
  - `start` while not in IDLE is ignored and is not queued.
- RD_LO:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=addr.
  - On `mem_ack`, latch `mem_rdata` into operand[7:0] and clear operand[15:8].
  - Next state: RD_HI if w16, else MODIFY.
- RD_HI:
  - Read at addr_hi = {addr[ADDR_W-1:16], addr[15:0]+1}. The offset wraps within the bank (0xFFFF → 0x0000); the bank is never carried.
  - On `mem_ack`, latch `mem_rdata` into operand[15:8], then go to MODIFY.
- MODIFY:
  - No bus request.
  - `alu_r` = operand.
  - Latch `alu_res` into result, and latch `alu_so`/`alu_zo`/`alu_co` into N/Z/C.
  - Next state: WR_HI if w16, else WR_LO.
- WR_HI: write result[15:8] to addr_hi; on `mem_ack`, go to WR_LO.
- WR_LO: write result[7:0] to addr; on `mem_ack`, go to DONE.
- DONE:
  - Pulse `done` and the flag write strobes.
  - Return to IDLE the same cycle EN=1.
- Flag enables, decoded from the captured ctrl:
  - Z: always.
  - N: unless secOp=101 (TSB/TRB).
  - C: only for fstOp[2]=0 (shift/rotate).
- `busy` = state≠IDLE.
- Bus outputs are registered from state. `mem_wdata` is 0 during reads.
- A `mem_ack` with `mem_req`=0 is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `alu_r`, result and operand = 0; all flags and strobes = 0; `alu_ctrl` = 0; `alu_w16` = 0.
- Latency with zero-wait bus (EN=1, `mem_ack` in the cycle `mem_req` rises), measured from `start` sampled at edge 0:
  - 8-bit: `done` high after edge 4.
  - 16-bit: `done` high after edge 6.
- Each bus wait cycle adds one cycle. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable until acked.
- EN=0 freezes everything, including a held `mem_req`; an ack arriving while EN=0 is not consumed.
- Reset assertion mid-operation:
  - Immediate return to IDLE; `mem_req` drops asynchronously.
  - A partially written 16-bit operand is left as is; there is no rollback.
- Bus order is read-lo, read-hi, write-hi, write-lo, matching the native 65C816.

## Structure
- ALUCtrl_r is already in package P65816; reuse it.
- Add to P65816:
  - the RMW state enum `rmw_state_e`;
  - localparams for the secOp TSB/TRB code (3'b101);
  - the shift-class test on fstOp[2].
- No sub-module. Flag-enable decode is an inline function; the ALU itself is instantiated by the parent, not inside this block.

## Test plan
- 8-bit ASL, [0x7E0010]=0x81, zero-wait → one read then one write of 0x02 to 0x7E0010; C=1, N=0, Z=0; `done` after edge 4; `flag_c_we`=1.
- 16-bit INC at 0x00FFFF, bytes 0xFF/0xFF → reads at 0x00FFFF then 0x000000; writes hi 0x00 to 0x000000, then lo 0x00 to 0x00FFFF; Z=1, N=0; `flag_c_we`=0; `done` after edge 6.
- 8-bit TSB, `acc`=0x0F, mem=0xF0 → writes 0xFF; Z=1 (mask AND is zero); only `flag_z_we` asserted.
- 16-bit ROR with 3 wait cycles on each access and EN toggling 1/0 → outputs held stable while waiting or frozen; written result is correct; `done` latency = 6 + 12 waits + EN-low cycles.
- `start` pulsed while busy → ignored; exactly one operation runs.
- `RST_N` asserted during WR_HI of a 16-bit DEC → `mem_req` drops without a clock edge; after release, state IDLE and all outputs at reset values.
